// File: rtl/pc_gen.sv
// ----------------------------------------------------------------------------
// pc_gen -- program counter generator with run / halt / fault control.
//
// Each cycle the block picks the next fetch address. In priority order the
// candidates are a taken conditional branch, JAL, JALR and the sequential
// pc + 4. Target arithmetic is 32-bit and wraps. A target that is misaligned
// or lies outside instruction memory is not loaded. Instead the block enters
// a sticky FAULT state and records the offending address. End-of-program
// moves the block to HALT, where it waits for a resume request.
//
// Parameters
//   ADDR_W     width of pc / pc_plus4 (8..32)
//   RESET_VEC  word-aligned PC loaded on reset and on halt
//   MEM_LIMIT  first invalid byte address; legal targets are < MEM_LIMIT
//   BR_SHIFT   left shift applied to the immediate for conditional branches
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous reset, active-high
//   stall             hold the PC this cycle
//   branch_taken      conditional branch resolved taken
//   jump[1:0]         00 none, 11 JAL, 01 JALR, 10 reserved (no jump)
//   immediate[31:0]   sign-extended offset
//   alu_result[31:0]  JALR target
//   program_finished  end-of-program indication
//   resume            restart request from HALT
//   pc                current fetch address (registered)
//   pc_plus4          pc + 4, modulo 2^ADDR_W (combinational)
//   state[1:0]        00 RUN, 01 HALT, 10 FAULT (registered)
//   fault_addr[31:0]  offending target captured on fault entry
//   retire_cnt[31:0]  saturating count of legal PC advances
// ----------------------------------------------------------------------------
module pc_gen #(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [32:0] MEM_LIMIT = 33'd128,
  parameter int unsigned BR_SHIFT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [1:0]        jump,
  input  logic [31:0]       immediate,
  input  logic [31:0]       alu_result,
  input  logic              program_finished,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [1:0]        state,
  output logic [31:0]       fault_addr,
  output logic [31:0]       retire_cnt
);

  // State encoding is fixed by the external interface.
  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_HALT  = 2'b01;
  localparam logic [1:0] ST_FAULT = 2'b10;

  localparam logic [1:0] JMP_JAL  = 2'b11;
  localparam logic [1:0] JMP_JALR = 2'b01;

  localparam logic [ADDR_W-1:0] RESET_PC = RESET_VEC[ADDR_W-1:0];

  // --------------------------------------------------------------------------
  // Target generation (32-bit, wrapping)
  // --------------------------------------------------------------------------
  logic [31:0] pc_ext;
  logic [31:0] seq_target;
  logic [31:0] br_target;
  logic [31:0] jal_target;
  logic [31:0] jalr_target;
  logic [31:0] target;
  logic        target_bad;

  always_comb begin
    // The PC is zero-extended. A negative offset from a narrow PC therefore
    // wraps to a huge 32-bit value, and the range check rejects that value.
    pc_ext      = 32'(pc);
    seq_target  = pc_ext + 32'd4;
    br_target   = pc_ext + (immediate << BR_SHIFT);
    jal_target  = pc_ext + immediate;
    jalr_target = {alu_result[31:1], 1'b0};
  end

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    target = seq_target;
    if (branch_taken) begin
      target = br_target;
    end else if (jump == JMP_JAL) begin
      target = jal_target;
    end else if (jump == JMP_JALR) begin
      target = jalr_target;
    end
  end

  // Alignment and range are both judged on the full 32-bit target, before
  // the target is truncated to ADDR_W.
  always_comb begin
    target_bad = (target[1:0] != 2'b00) || ({1'b0, target} >= MEM_LIMIT);
  end

  always_comb begin
    pc_plus4 = pc + ADDR_W'(32'd4);
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] pc_d;
  logic [1:0]        state_d;
  logic [31:0]       fault_addr_d;
  logic [31:0]       retire_cnt_d;

  always_comb begin
    pc_d         = pc;
    state_d      = state;
    fault_addr_d = fault_addr;
    retire_cnt_d = retire_cnt;

    case (state)
      ST_RUN: begin
        // End-of-program outranks a stall and any redirect.
        if (program_finished) begin
          pc_d    = RESET_PC;
          state_d = ST_HALT;
        end else if (!stall) begin
          if (target_bad) begin
            fault_addr_d = target;
            state_d      = ST_FAULT;
          end else begin
            pc_d = ADDR_W'(target);
            if (retire_cnt != 32'hFFFF_FFFF) begin
              retire_cnt_d = retire_cnt + 32'd1;
            end
          end
        end
      end

      ST_HALT: begin
        // The PC stays parked at the reset vector. As a result, the first
        // fetch after resume is RESET_VEC.
        pc_d = RESET_PC;
        if (resume) begin
          state_d = ST_RUN;
        end
      end

      ST_FAULT: begin
        // Sticky: only rst leaves this state.
      end

      default: begin
        // Encoding 11 cannot be reached. If an upset lands the state here,
        // fail safe and record where it happened.
        fault_addr_d = pc_ext;
        state_d      = ST_FAULT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. Every register then
  // samples its pre-edge inputs, whatever order the statements are written in.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      state      <= ST_RUN;
      fault_addr <= 32'h0000_0000;
      retire_cnt <= 32'h0000_0000;
    end else begin
      pc         <= pc_d;
      state      <= state_d;
      fault_addr <= fault_addr_d;
      retire_cnt <= retire_cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// ----------------------------------------------------------------------------
// tb_pc_gen -- scoreboard bench for pc_gen.
//
// The driver applies one input vector per cycle on the falling edge. It
// advances a behavioural model and pushes the expected post-edge outputs into
// a queue. A separate monitor pops one entry after every rising edge and
// compares it with the default-parameter DUT. A second instance, with
// ADDR_W=8 and MEM_LIMIT=256, shares the same inputs. It is checked directly
// in the narrow-PC wrap-around scenario.
// ----------------------------------------------------------------------------
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [1:0]  jump = 2'b00;
  logic [31:0] immediate = 32'h0;
  logic [31:0] alu_result = 32'h0;
  logic        program_finished = 1'b0;
  logic        resume = 1'b0;

  logic [31:0] pc, pc_plus4, fault_addr, retire_cnt;
  logic [1:0]  state;
  logic [7:0]  pc8, pc_plus4_8;
  logic [31:0] fault_addr8, retire_cnt8;
  logic [1:0]  state8;

  always #5 clk = ~clk;

  pc_gen u_dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .jump(jump), .immediate(immediate), .alu_result(alu_result),
    .program_finished(program_finished), .resume(resume),
    .pc(pc), .pc_plus4(pc_plus4), .state(state),
    .fault_addr(fault_addr), .retire_cnt(retire_cnt)
  );

  pc_gen #(.ADDR_W(8), .MEM_LIMIT(33'd256)) u_dut8 (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .jump(jump), .immediate(immediate), .alu_result(alu_result),
    .program_finished(program_finished), .resume(resume),
    .pc(pc8), .pc_plus4(pc_plus4_8), .state(state8),
    .fault_addr(fault_addr8), .retire_cnt(retire_cnt8)
  );

  // --------------------------------------------------------------------------
  // Scoreboard and checking
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  state;
    logic [31:0] fault_addr;
    logic [31:0] retire_cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("pc",         pc,         e.pc);
        check("pc_plus4",   pc_plus4,   e.pc_plus4);
        check("state",      {30'd0, state}, {30'd0, e.state});
        check("fault_addr", fault_addr, e.fault_addr);
        check("retire_cnt", retire_cnt, e.retire_cnt);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Reference model: default parameters (RESET_VEC 0, MEM_LIMIT 128, shift 1)
  // --------------------------------------------------------------------------
  typedef enum {M_RUN, M_HALT, M_FAULT} mstate_e;

  mstate_e     m_st = M_RUN;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_fa = 32'h0;
  logic [31:0] m_rc = 32'h0;

  function automatic logic [1:0] enc(input mstate_e s);
    case (s)
      M_RUN:   return 2'b00;
      M_HALT:  return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic st, input logic br,
                            input logic [1:0] j, input logic [31:0] imm,
                            input logic [31:0] alu, input logic pf, input logic rs);
    logic [31:0] t;
    if (r) begin
      m_pc = 32'h0; m_st = M_RUN; m_fa = 32'h0; m_rc = 32'h0;
    end else if (m_st == M_RUN) begin
      if (pf) begin
        m_pc = 32'h0;
        m_st = M_HALT;
      end else if (!st) begin
        if (br)            t = m_pc + imm * 2;
        else if (j == 2'b11) t = m_pc + imm;
        else if (j == 2'b01) t = alu & 32'hFFFF_FFFE;
        else               t = m_pc + 4;
        if ((t % 4) != 0 || t >= 128) begin
          m_fa = t;
          m_st = M_FAULT;
        end else begin
          m_pc = t;
          if (m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
        end
      end
    end else if (m_st == M_HALT) begin
      m_pc = 32'h0;
      if (rs) m_st = M_RUN;
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic br,
                       input logic [1:0] j, input logic [31:0] imm,
                       input logic [31:0] alu, input logic pf, input logic rs);
    exp_t e;
    @(negedge clk);
    rst = r; stall = st; branch_taken = br; jump = j;
    immediate = imm; alu_result = alu; program_finished = pf; resume = rs;
    model_step(r, st, br, j, imm, alu, pf, rs);
    e.pc = m_pc; e.pc_plus4 = m_pc + 4; e.state = enc(m_st);
    e.fault_addr = m_fa; e.retire_cnt = m_rc;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 2'b00, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 2'b00, 32'h0, 32'h0, 0, 0);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin : driver
    int guard;
    // Sequential fetch after reset.
    do_reset();
    idle(5);

    // Branch beats JAL, then JALR clears bit 0.
    do_reset();
    idle(2);
    drive(0, 0, 1, 2'b11, 32'd6, 32'h0, 0, 0);
    drive(0, 0, 0, 2'b01, 32'h0, 32'h21, 0, 0);

    // Stall discards a taken branch.
    do_reset();
    idle(3);
    for (int k = 0; k < 3; k++) drive(0, 1, 1, 2'b00, 32'd8, 32'h0, 0, 0);
    idle(1);

    // Sequential step off the end of memory, resume ignored in FAULT.
    do_reset();
    drive(0, 0, 0, 2'b11, 32'd124, 32'h0, 0, 0);
    idle(1);
    drive(0, 0, 0, 2'b00, 32'h0, 32'h0, 0, 1);
    drive(0, 0, 0, 2'b00, 32'h0, 32'h0, 1, 1);
    do_reset();

    // End-of-program outranks stall; HALT ignores it; resume restarts at 0.
    drive(0, 0, 0, 2'b11, 32'd40, 32'h0, 0, 0);
    drive(0, 1, 1, 2'b11, 32'd8, 32'h0, 1, 0);
    for (int k = 0; k < 4; k++) drive(0, 0, 0, 2'b00, 32'h0, 32'h0, 1, 0);
    drive(0, 0, 0, 2'b00, 32'h0, 32'h0, 0, 1);
    idle(2);

    // Reserved jump encoding acts as sequential; misaligned JALR faults.
    drive(0, 0, 0, 2'b10, 32'd64, 32'd64, 0, 0);
    drive(0, 0, 0, 2'b01, 32'h0, 32'h0000_0006, 0, 0);
    do_reset();

    // Negative JAL from 0x10: 32-bit target 0xFFFF_FFFC is out of range.
    do_reset();
    idle(4);
    drive(0, 0, 0, 2'b11, 32'hFFFF_FFEC, 32'h0, 0, 0);
    @(posedge clk);
    #2;
    check("w8_state",      {30'd0, state8}, 32'd2);
    check("w8_pc",         {24'd0, pc8}, 32'h10);
    check("w8_pc_plus4",   {24'd0, pc_plus4_8}, 32'h14);
    check("w8_fault_addr", fault_addr8, 32'hFFFF_FFFC);
    check("w8_retire_cnt", retire_cnt8, 32'd4);

    // Randomised traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        r, st, br, pf, rs;
      logic [1:0]  j;
      logic [31:0] imm, alu;
      int          v;
      r   = ($urandom_range(0, 59) == 0);
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 3) == 0);
      j   = 2'($urandom_range(0, 3));
      v   = int'($urandom_range(0, 32)) - 16;
      imm = 32'(v * 2);
      if ($urandom_range(0, 15) == 0) imm = $urandom;
      alu = 32'($urandom_range(0, 150));
      pf  = ($urandom_range(0, 39) == 0);
      rs  = ($urandom_range(0, 2) == 0);
      drive(r, st, br, j, imm, alu, pf, rs);
    end

    // Drain the scoreboard with a bounded wait.
    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
